// File: rtl/sim_memory_requester_pkg.sv
// Shared definitions for the CPU-to-memory requester: access sizes, the
// in-flight load tag layout, and the lane mask / store / load helpers.
package sim_memory_requester_pkg;

  typedef enum logic [1:0] {
    ORDER_BYTE = 2'b00,
    ORDER_HALF = 2'b01,
    ORDER_WORD = 2'b10,
    ORDER_NONE = 2'b11
  } order_e;

  localparam int TAG_W = 8;

  // Everything needed to pick a load result out of the returned dword.
  typedef struct packed {
    logic [1:0] pad;
    logic [2:0] addr_lo;
    order_e     order;
    logic       sgn;
  } tag_t;

  function automatic logic is_illegal(input order_e order, input logic [1:0] a);
    return (order == ORDER_NONE) ||
           (order == ORDER_HALF && a[0]) ||
           (order == ORDER_WORD && a != 2'b00);
  endfunction

  function automatic logic [3:0] lane_mask(input order_e order, input logic [1:0] a);
    case (order)
      ORDER_BYTE: return 4'b0001 << a;
      ORDER_HALF: return a[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input order_e order, input logic [31:0] d);
    case (order)
      ORDER_BYTE: return {4{d[7:0]}};
      ORDER_HALF: return {2{d[15:0]}};
      default:    return d;
    endcase
  endfunction

  function automatic logic [31:0] extract_load(input tag_t t, input logic [63:0] dw);
    logic [31:0] half;
    logic [7:0]  b;
    logic [15:0] h;
    half = t.addr_lo[2] ? dw[63:32] : dw[31:0];
    b    = 8'(half >> {t.addr_lo[1:0], 3'b000});
    h    = t.addr_lo[1] ? half[31:16] : half[15:0];
    case (t.order)
      ORDER_BYTE: return {{24{t.sgn & b[7]}}, b};
      ORDER_HALF: return {{16{t.sgn & h[15]}}, h};
      default:    return half;
    endcase
  endfunction

endpackage

// File: rtl/mist1032sa_sync_fifo.sv
// Single-clock show-ahead FIFO; head entry is visible on oRD_DATA while not empty.
module mist1032sa_sync_fifo #(
  parameter int P_N       = 8,
  parameter int P_DEPTH   = 4,
  parameter int P_DEPTH_N = 2
) (
  input  logic           iCLOCK,
  input  logic           inRESET,
  input  logic           iWR_EN,
  input  logic [P_N-1:0] iWR_DATA,
  output logic           oWR_FULL,
  input  logic           iRD_EN,
  output logic [P_N-1:0] oRD_DATA,
  output logic           oRD_EMPTY
);

  logic [P_N-1:0]     mem_q [P_DEPTH];
  logic [P_DEPTH_N:0] wr_ptr_q, wr_ptr_d;
  logic [P_DEPTH_N:0] rd_ptr_q, rd_ptr_d;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign oRD_EMPTY = (wr_ptr_q == rd_ptr_q);
  assign oWR_FULL  = (wr_ptr_q[P_DEPTH_N] != rd_ptr_q[P_DEPTH_N]) &&
                     (wr_ptr_q[P_DEPTH_N-1:0] == rd_ptr_q[P_DEPTH_N-1:0]);
  assign oRD_DATA  = mem_q[rd_ptr_q[P_DEPTH_N-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (iWR_EN && !oWR_FULL)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (iRD_EN && !oRD_EMPTY) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iWR_EN && !oWR_FULL) mem_q[wr_ptr_q[P_DEPTH_N-1:0]] <= iWR_DATA;
  end

endmodule

// File: rtl/sim_memory_requester.sv
// Turns CPU byte/half/word accesses into masked 32-bit memory commands and
// aligns in-order 64-bit read responses back into extended load results.
module sim_memory_requester
  import sim_memory_requester_pkg::*;
#(
  parameter int P_TAG_DEPTH   = 4,
  parameter int P_TAG_DEPTH_N = 2
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iCPU_REQ,
  output logic        oCPU_BUSY,
  input  logic [1:0]  iCPU_ORDER,
  input  logic        iCPU_RW,
  input  logic        iCPU_SIGNED,
  input  logic [31:0] iCPU_ADDR,
  input  logic [31:0] iCPU_DATA,
  output logic        oCPU_VALID,
  output logic [31:0] oCPU_DATA,
  input  logic        iCPU_LOCK,
  output logic        oCPU_ERR,
  output logic        oMEMORY_REQ,
  output logic [1:0]  oMEMORY_ORDER,
  output logic [3:0]  oMEMORY_MASK,
  output logic        oMEMORY_RW,
  output logic [31:0] oMEMORY_ADDR,
  output logic [31:0] oMEMORY_DATA,
  input  logic        iMEMORY_LOCK,
  input  logic        iMEMORY_VALID,
  input  logic [63:0] iMEMORY_DATA,
  output logic        oMEMORY_LOCK,
  output logic        oPROTOCOL_ERR
);

  typedef enum logic {ST_IDLE, ST_ISSUE} state_e;

  state_e      state_q, state_d;
  order_e      order_q, order_d;
  logic [3:0]  mask_q, mask_d;
  logic        rw_q, rw_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        perr_q, perr_d;

  logic        accept, illegal, push, pop;
  logic        fifo_full, fifo_empty;
  logic [TAG_W-1:0] fifo_rd;
  tag_t        push_tag;
  order_e      cpu_order;

  assign cpu_order = order_e'(iCPU_ORDER);
  assign illegal   = is_illegal(cpu_order, iCPU_ADDR[1:0]);
  assign oCPU_BUSY = (state_q == ST_ISSUE) || (!iCPU_RW && fifo_full);
  assign accept    = iCPU_REQ && !oCPU_BUSY;
  assign push      = accept && !illegal && !iCPU_RW;
  // A response is only taken while the result register can accept it.
  assign pop       = iMEMORY_VALID && !fifo_empty && !oMEMORY_LOCK;

  assign push_tag  = '{pad: 2'b00, addr_lo: iCPU_ADDR[2:0], order: cpu_order, sgn: iCPU_SIGNED};

  mist1032sa_sync_fifo #(
    .P_N      (TAG_W),
    .P_DEPTH  (P_TAG_DEPTH),
    .P_DEPTH_N(P_TAG_DEPTH_N)
  ) u_tag_fifo (
    .iCLOCK   (iCLOCK),
    .inRESET  (inRESET),
    .iWR_EN   (push),
    .iWR_DATA (push_tag),
    .oWR_FULL (fifo_full),
    .iRD_EN   (pop),
    .oRD_DATA (fifo_rd),
    .oRD_EMPTY(fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    order_d = order_q;
    mask_d  = mask_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    perr_d  = perr_q | (iMEMORY_VALID && fifo_empty);
    valid_d = valid_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && illegal) begin
          err_d = 1'b1;
        end else if (accept) begin
          state_d = ST_ISSUE;
          order_d = cpu_order;
          mask_d  = lane_mask(cpu_order, iCPU_ADDR[1:0]);
          rw_d    = iCPU_RW;
          addr_d  = {iCPU_ADDR[31:2], 2'b00};
          wdata_d = replicate(cpu_order, iCPU_DATA);
        end
      end
      ST_ISSUE: if (!iMEMORY_LOCK) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (pop) begin
      valid_d = 1'b1;
      rdata_d = extract_load(tag_t'(fifo_rd), iMEMORY_DATA);
    end else if (valid_q && !iCPU_LOCK) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      state_q <= ST_IDLE;
      order_q <= ORDER_BYTE;
      mask_q  <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      order_q <= order_d;
      mask_q  <= mask_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      perr_q  <= perr_d;
    end
  end

  assign oMEMORY_REQ   = (state_q == ST_ISSUE);
  assign oMEMORY_ORDER = order_q;
  assign oMEMORY_MASK  = mask_q;
  assign oMEMORY_RW    = rw_q;
  assign oMEMORY_ADDR  = addr_q;
  assign oMEMORY_DATA  = wdata_q;
  assign oCPU_VALID    = valid_q;
  assign oCPU_DATA     = rdata_q;
  assign oCPU_ERR      = err_q;
  assign oPROTOCOL_ERR = perr_q;
  assign oMEMORY_LOCK  = valid_q && iCPU_LOCK;

endmodule

// File: tb/tb_sim_memory_requester.sv
// Directed scenarios for sim_memory_requester with hand-computed expectations.
module tb_sim_memory_requester;

  logic        iCLOCK = 1'b0;
  logic        inRESET = 1'b0;
  logic        iCPU_REQ = 1'b0;
  logic        oCPU_BUSY;
  logic [1:0]  iCPU_ORDER = 2'b00;
  logic        iCPU_RW = 1'b0;
  logic        iCPU_SIGNED = 1'b0;
  logic [31:0] iCPU_ADDR = '0;
  logic [31:0] iCPU_DATA = '0;
  logic        oCPU_VALID;
  logic [31:0] oCPU_DATA;
  logic        iCPU_LOCK = 1'b0;
  logic        oCPU_ERR;
  logic        oMEMORY_REQ;
  logic [1:0]  oMEMORY_ORDER;
  logic [3:0]  oMEMORY_MASK;
  logic        oMEMORY_RW;
  logic [31:0] oMEMORY_ADDR;
  logic [31:0] oMEMORY_DATA;
  logic        iMEMORY_LOCK = 1'b0;
  logic        iMEMORY_VALID = 1'b0;
  logic [63:0] iMEMORY_DATA = '0;
  logic        oMEMORY_LOCK;
  logic        oPROTOCOL_ERR;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] DW = 64'h89ABCDEF_01234567;

  always #5 iCLOCK = ~iCLOCK;

  sim_memory_requester dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET),
    .iCPU_REQ(iCPU_REQ), .oCPU_BUSY(oCPU_BUSY), .iCPU_ORDER(iCPU_ORDER),
    .iCPU_RW(iCPU_RW), .iCPU_SIGNED(iCPU_SIGNED), .iCPU_ADDR(iCPU_ADDR),
    .iCPU_DATA(iCPU_DATA), .oCPU_VALID(oCPU_VALID), .oCPU_DATA(oCPU_DATA),
    .iCPU_LOCK(iCPU_LOCK), .oCPU_ERR(oCPU_ERR),
    .oMEMORY_REQ(oMEMORY_REQ), .oMEMORY_ORDER(oMEMORY_ORDER),
    .oMEMORY_MASK(oMEMORY_MASK), .oMEMORY_RW(oMEMORY_RW),
    .oMEMORY_ADDR(oMEMORY_ADDR), .oMEMORY_DATA(oMEMORY_DATA),
    .iMEMORY_LOCK(iMEMORY_LOCK), .iMEMORY_VALID(iMEMORY_VALID),
    .iMEMORY_DATA(iMEMORY_DATA), .oMEMORY_LOCK(oMEMORY_LOCK),
    .oPROTOCOL_ERR(oPROTOCOL_ERR)
  );

  task automatic tick();
    @(posedge iCLOCK);
    #1;
  endtask

  // Presents one CPU request for a single edge; the command is then in ISSUE.
  task automatic cpu_req(input logic rw, input logic [1:0] order, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] data);
    iCPU_RW = rw; iCPU_ORDER = order; iCPU_SIGNED = sgn;
    iCPU_ADDR = addr; iCPU_DATA = data; iCPU_REQ = 1'b1;
    tick();
    iCPU_REQ = 1'b0;
    $display("cpu req rw=%0d order=%0d signed=%0d addr=%h data=%h", rw, order, sgn, addr, data);
  endtask

  task automatic mem_resp(input logic [63:0] d);
    iMEMORY_VALID = 1'b1; iMEMORY_DATA = d;
    tick();
    iMEMORY_VALID = 1'b0;
    $display("mem resp data=%h -> cpu valid=%0d data=%h", d, oCPU_VALID, oCPU_DATA);
  endtask

  task automatic test_reset();
    inRESET = 1'b0;
    tick(); tick();
    inRESET = 1'b1;
    #1;
    n_checks++;
    if ({oMEMORY_REQ, oCPU_VALID, oCPU_ERR, oPROTOCOL_ERR, oCPU_BUSY} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000",
        {oMEMORY_REQ, oCPU_VALID, oCPU_ERR, oPROTOCOL_ERR, oCPU_BUSY});
    end
    n_checks++;
    if ({oCPU_DATA, oMEMORY_ADDR, oMEMORY_DATA, oMEMORY_MASK} !== 100'b0) begin
      n_fail++; $display("FAIL reset_data: cpu_data=%h addr=%h wdata=%h mask=%b want all 0",
        oCPU_DATA, oMEMORY_ADDR, oMEMORY_DATA, oMEMORY_MASK);
    end
  endtask

  task automatic test_word_load();
    cpu_req(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0);
    n_checks++;
    if ({oMEMORY_REQ, oMEMORY_RW, oMEMORY_MASK, oMEMORY_ADDR} !== {1'b1, 1'b0, 4'b1111, 32'h0000_000C}) begin
      n_fail++; $display("FAIL word_load_cmd: req=%0d rw=%0d mask=%b addr=%h want 1 0 1111 0000000c",
        oMEMORY_REQ, oMEMORY_RW, oMEMORY_MASK, oMEMORY_ADDR);
    end
    tick();
    n_checks++;
    if (oMEMORY_REQ !== 1'b0) begin
      n_fail++; $display("FAIL word_load_idle: req=%0d want 0", oMEMORY_REQ);
    end
    iMEMORY_VALID = 1'b1; iMEMORY_DATA = DW;
    #1;
    n_checks++;
    if (oCPU_VALID !== 1'b0) begin
      n_fail++; $display("FAIL word_load_early: valid=%0d want 0 before edge", oCPU_VALID);
    end
    mem_resp(DW);
    n_checks++;
    if ({oCPU_VALID, oCPU_DATA} !== {1'b1, 32'h89AB_CDEF}) begin
      n_fail++; $display("FAIL word_load_data: valid=%0d data=%h want 1 89abcdef", oCPU_VALID, oCPU_DATA);
    end
    tick();
    n_checks++;
    if (oCPU_VALID !== 1'b0) begin
      n_fail++; $display("FAIL word_load_consume: valid=%0d want 0", oCPU_VALID);
    end
  endtask

  task automatic test_narrow_loads();
    cpu_req(1'b0, 2'b00, 1'b1, 32'h0000_000F, 32'h0);
    n_checks++;
    if ({oMEMORY_MASK, oMEMORY_ADDR, oMEMORY_ORDER} !== {4'b1000, 32'h0000_000C, 2'b00}) begin
      n_fail++; $display("FAIL sbyte_cmd: mask=%b addr=%h order=%b want 1000 0000000c 00",
        oMEMORY_MASK, oMEMORY_ADDR, oMEMORY_ORDER);
    end
    tick();
    mem_resp(DW);
    n_checks++;
    if (oCPU_DATA !== 32'hFFFF_FF89) begin
      n_fail++; $display("FAIL sbyte_data: got %h want ffffff89", oCPU_DATA);
    end
    tick();
    cpu_req(1'b0, 2'b01, 1'b0, 32'h0000_0008, 32'h0);
    n_checks++;
    if (oMEMORY_MASK !== 4'b0011) begin
      n_fail++; $display("FAIL uhalf_mask: got %b want 0011", oMEMORY_MASK);
    end
    tick();
    mem_resp(DW);
    n_checks++;
    if (oCPU_DATA !== 32'h0000_4567) begin
      n_fail++; $display("FAIL uhalf_data: got %h want 00004567", oCPU_DATA);
    end
    tick();
  endtask

  task automatic test_store();
    cpu_req(1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h0000_1234);
    n_checks++;
    if ({oMEMORY_REQ, oMEMORY_RW, oMEMORY_MASK, oMEMORY_ADDR, oMEMORY_DATA} !==
        {1'b1, 1'b1, 4'b1100, 32'h0000_0004, 32'h1234_1234}) begin
      n_fail++; $display("FAIL half_store: req=%0d rw=%0d mask=%b addr=%h data=%h want 1 1 1100 00000004 12341234",
        oMEMORY_REQ, oMEMORY_RW, oMEMORY_MASK, oMEMORY_ADDR, oMEMORY_DATA);
    end
    tick();
  endtask

  task automatic test_misaligned();
    cpu_req(1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0);
    n_checks++;
    if ({oCPU_ERR, oMEMORY_REQ} !== 2'b10) begin
      n_fail++; $display("FAIL misaligned_word: err=%0d req=%0d want 1 0", oCPU_ERR, oMEMORY_REQ);
    end
    tick();
    n_checks++;
    if ({oCPU_ERR, oMEMORY_REQ} !== 2'b00) begin
      n_fail++; $display("FAIL misaligned_pulse: err=%0d req=%0d want 0 0", oCPU_ERR, oMEMORY_REQ);
    end
    cpu_req(1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'h0);
    n_checks++;
    if ({oCPU_ERR, oMEMORY_REQ} !== 2'b10) begin
      n_fail++; $display("FAIL illegal_order: err=%0d req=%0d want 1 0", oCPU_ERR, oMEMORY_REQ);
    end
    tick();
  endtask

  task automatic test_mem_lock();
    iMEMORY_LOCK = 1'b1;
    cpu_req(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({oMEMORY_REQ, oCPU_BUSY, oMEMORY_ADDR, oMEMORY_DATA, oMEMORY_MASK} !==
          {1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'b1111}) begin
        n_fail++; $display("FAIL mem_lock_hold[%0d]: req=%0d busy=%0d addr=%h data=%h mask=%b",
          i, oMEMORY_REQ, oCPU_BUSY, oMEMORY_ADDR, oMEMORY_DATA, oMEMORY_MASK);
      end
      tick();
    end
    iMEMORY_LOCK = 1'b0;
    tick();
    n_checks++;
    if ({oMEMORY_REQ, oCPU_BUSY} !== 2'b00) begin
      n_fail++; $display("FAIL mem_lock_release: req=%0d busy=%0d want 0 0", oMEMORY_REQ, oCPU_BUSY);
    end
  endtask

  task automatic test_back_to_back();
    cpu_req(1'b0, 2'b00, 1'b0, 32'h0000_0008, 32'h0); tick();
    cpu_req(1'b0, 2'b00, 1'b1, 32'h0000_000E, 32'h0); tick();
    cpu_req(1'b0, 2'b01, 1'b0, 32'h0000_000A, 32'h0); tick();
    cpu_req(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0); tick();
    iCPU_RW = 1'b0; iCPU_REQ = 1'b1;
    #1;
    n_checks++;
    if (oCPU_BUSY !== 1'b1) begin
      n_fail++; $display("FAIL full_load_busy: busy=%0d want 1", oCPU_BUSY);
    end
    iCPU_REQ = 1'b0;
    iCPU_RW = 1'b1;
    #1;
    n_checks++;
    if (oCPU_BUSY !== 1'b0) begin
      n_fail++; $display("FAIL full_store_busy: busy=%0d want 0", oCPU_BUSY);
    end
    cpu_req(1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_00AB);
    n_checks++;
    if ({oMEMORY_REQ, oMEMORY_RW, oMEMORY_MASK, oMEMORY_DATA} !== {1'b1, 1'b1, 4'b0010, 32'hABAB_ABAB}) begin
      n_fail++; $display("FAIL full_store_cmd: req=%0d rw=%0d mask=%b data=%h want 1 1 0010 abababab",
        oMEMORY_REQ, oMEMORY_RW, oMEMORY_MASK, oMEMORY_DATA);
    end
    tick();
    iCPU_LOCK = 1'b1;
    mem_resp(DW);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({oCPU_VALID, oMEMORY_LOCK, oCPU_DATA} !== {1'b1, 1'b1, 32'h0000_0067}) begin
        n_fail++; $display("FAIL cpu_lock_hold[%0d]: valid=%0d mlock=%0d data=%h want 1 1 00000067",
          i, oCPU_VALID, oMEMORY_LOCK, oCPU_DATA);
      end
      tick();
    end
    // Release the CPU lock while the next responses stream in every cycle.
    iCPU_LOCK = 1'b0;
    mem_resp(DW);
    n_checks++;
    if ({oCPU_VALID, oCPU_DATA} !== {1'b1, 32'hFFFF_FFAB}) begin
      n_fail++; $display("FAIL overlap_sbyte: valid=%0d data=%h want 1 ffffffab", oCPU_VALID, oCPU_DATA);
    end
    mem_resp(DW);
    n_checks++;
    if ({oCPU_VALID, oCPU_DATA} !== {1'b1, 32'h0000_0123}) begin
      n_fail++; $display("FAIL overlap_half: valid=%0d data=%h want 1 00000123", oCPU_VALID, oCPU_DATA);
    end
    mem_resp(DW);
    n_checks++;
    if ({oCPU_VALID, oCPU_DATA} !== {1'b1, 32'h0123_4567}) begin
      n_fail++; $display("FAIL overlap_word: valid=%0d data=%h want 1 01234567", oCPU_VALID, oCPU_DATA);
    end
    tick();
    n_checks++;
    if ({oCPU_VALID, oPROTOCOL_ERR} !== 2'b00) begin
      n_fail++; $display("FAIL drain_done: valid=%0d perr=%0d want 0 0", oCPU_VALID, oPROTOCOL_ERR);
    end
  endtask

  task automatic test_reset_midop();
    cpu_req(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0); tick();
    cpu_req(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0);
    inRESET = 1'b0;
    tick();
    inRESET = 1'b1;
    n_checks++;
    if ({oMEMORY_REQ, oCPU_VALID, oCPU_ERR, oPROTOCOL_ERR, oCPU_DATA, oMEMORY_ADDR, oMEMORY_MASK} !== 72'b0) begin
      n_fail++; $display("FAIL midop_reset: req=%0d valid=%0d err=%0d perr=%0d data=%h addr=%h mask=%b want all 0",
        oMEMORY_REQ, oCPU_VALID, oCPU_ERR, oPROTOCOL_ERR, oCPU_DATA, oMEMORY_ADDR, oMEMORY_MASK);
    end
    mem_resp(DW);
    n_checks++;
    if ({oPROTOCOL_ERR, oCPU_VALID} !== 2'b10) begin
      n_fail++; $display("FAIL midop_perr: perr=%0d valid=%0d want 1 0", oPROTOCOL_ERR, oCPU_VALID);
    end
    tick();
    n_checks++;
    if (oPROTOCOL_ERR !== 1'b1) begin
      n_fail++; $display("FAIL perr_sticky: perr=%0d want 1", oPROTOCOL_ERR);
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_narrow_loads();
    test_store();
    test_misaligned();
    test_mem_lock();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sim_memory_requester.md
SIM_MEMORY_REQUESTER -- requirements
Module: sim_memory_requester

Interface
REQ-001 Parameter P_TAG_DEPTH, default 4: maximum outstanding loads.
REQ-002 Parameter P_TAG_DEPTH_N, default 2: log2(P_TAG_DEPTH).
REQ-003 iCLOCK  in  1  sole clock; all state updates on its rising edge.
REQ-004 inRESET  in  1  reset, synchronous and active-low.
REQ-005 iCPU_REQ  in  1  CPU access request.
REQ-006 oCPU_BUSY  out  1  request not accepted this cycle.
REQ-007 iCPU_ORDER  in  2  size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 iCPU_RW / iCPU_SIGNED  in  1 each  1=write; 1=sign-extend load.
REQ-009 iCPU_ADDR / iCPU_DATA  in  32 each  byte address; store data, LSB-aligned.
REQ-010 oCPU_VALID / oCPU_DATA  out  1/32  load result strobe; extended result.
REQ-011 iCPU_LOCK  in  1  CPU cannot take a load result.
REQ-012 oCPU_ERR  out  1  one-cycle pulse on a rejected misaligned/illegal request.
REQ-013 oMEMORY_REQ, oMEMORY_ORDER[2], oMEMORY_MASK[4], oMEMORY_RW, oMEMORY_ADDR[32], oMEMORY_DATA[32]  out  command to memory.
REQ-014 iMEMORY_LOCK  in  1  memory busy; command held.
REQ-015 iMEMORY_VALID / iMEMORY_DATA  in  1/64  read response strobe; 64-bit dword.
REQ-016 oMEMORY_LOCK  out  1  backpressure on read responses.
REQ-017 oPROTOCOL_ERR  out  1  sticky: response arrived with no outstanding load.

Function
REQ-018 Command FSM states: IDLE (no command held), ISSUE (command held on memory port).
REQ-019 oCPU_BUSY = (state==ISSUE) or (iCPU_RW==0 and tag FIFO full).
REQ-020 Accept = iCPU_REQ and not oCPU_BUSY; a legal accept captures the command and moves to ISSUE on the next edge.
REQ-021 Illegal accept: ORDER 11, halfword with ADDR[0]=1, or word with ADDR[1:0]!=0; pulses oCPU_ERR next cycle, stays IDLE, issues nothing, pushes no tag.
REQ-022 In ISSUE, oMEMORY_REQ=1; outputs are stable until an edge with iMEMORY_LOCK=0, which returns the FSM to IDLE.
REQ-023 oMEMORY_ADDR = captured address with bits [1:0] forced to 0; oMEMORY_ORDER = captured order.
REQ-024 Mask, little-endian: byte 0001<<ADDR[1:0]; halfword ADDR[1] ? 1100 : 0011; word 1111.
REQ-025 Store data replicated to all lanes: byte {4{D[7:0]}}, halfword {2{D[15:0]}}, word D.
REQ-026 Load accept pushes tag {ADDR[2:0], ORDER, SIGNED} in the same edge as capture; stores push nothing.
REQ-027 Responses return in order; each edge with iMEMORY_VALID=1 pops one tag.
REQ-028 Extraction: 32-bit half = ADDR[2] ? data[63:32] : data[31:0]; lane by ADDR[1:0]; zero- or sign-extend to 32 bits per SIGNED.
REQ-029 Output register loads on the pop edge, so oCPU_VALID asserts one cycle after iMEMORY_VALID and holds with stable data while iCPU_LOCK=1.
REQ-030 oMEMORY_LOCK = oCPU_VALID and iCPU_LOCK.
REQ-031 Consume and new response in the same cycle: the output register is overwritten and oCPU_VALID stays 1.
REQ-032 Push and pop in the same cycle are both honoured; occupancy is unchanged.
REQ-033 With the tag FIFO full, stores are still accepted.
REQ-034 iMEMORY_VALID with the tag FIFO empty sets oPROTOCOL_ERR; the data is dropped and no pop occurs.

Reset
REQ-035 With inRESET=0 at an edge: state IDLE, tag FIFO empty, oMEMORY_REQ=0, oCPU_VALID=0, oCPU_ERR=0, oPROTOCOL_ERR=0, oCPU_DATA=0, held command fields=0.
REQ-036 Reset mid-operation drops the held command and all outstanding tags; responses arriving afterwards set oPROTOCOL_ERR.

Structure
REQ-037 Shared package holds the order encodings (BYTE, HALF, WORD, NONE) and the tag field layout.
REQ-038 The tag FIFO is the existing mist1032sa_sync_fifo instance, width 8, depth P_TAG_DEPTH; no other sub-module.

Verification
REQ-039 Memory dword at 0x08 = 0x89ABCDEF_01234567; word load at 0x0C -> oCPU_DATA=0x89ABCDEF, one cycle after iMEMORY_VALID.
REQ-040 Same dword; signed byte load at 0x0F -> 0xFFFFFF89; unsigned halfword load at 0x08 -> 0x00004567.
REQ-041 Halfword store 0x1234 at 0x06 -> oMEMORY_ADDR=0x04, MASK=1100, DATA=0x12341234, RW=1.
REQ-042 Word load at 0x02 -> oCPU_ERR pulse, oMEMORY_REQ stays 0.
REQ-043 Hold iMEMORY_LOCK=1 for 5 cycles during ISSUE -> command stable and oCPU_BUSY=1 throughout; four back-to-back loads with responses withheld -> fifth load busy, a store still accepted; iCPU_LOCK=1 -> oMEMORY_LOCK=1 and oCPU_DATA held.
REQ-044 Reset with 2 loads outstanding, then 1 response -> all outputs at reset values, then oPROTOCOL_ERR=1.
